// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and memCtrl.
// Hits respond one cycle after the request; misses issue a single word read and fill the line.
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_BITS  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetcher_ce,
    input  logic [31:0] in_fetcher_pc,
    output logic        out_fetcher_ce,
    output logic [31:0] out_fetcher_instr,
    output logic        out_mem_ce,
    output logic [31:0] out_mem_pc,
    input  logic        in_mem_ce,
    input  logic [31:0] in_mem_instr,
    input  logic        in_rob_misbranch
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        DONE
    } state_t;

    state_t                  state_q;
    logic                    fetcher_ce_q;
    logic [31:0]             fetcher_instr_q;
    logic                    mem_ce_q;
    logic [31:0]             mem_pc_q;

    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES];

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    req_hit;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    fill_en;
    logic                    unused_pc_bits;

    assign req_idx        = in_fetcher_pc[INDEX_BITS+1:2];
    assign req_tag        = in_fetcher_pc[ADDR_BITS-1:INDEX_BITS+2];
    assign req_hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_pc_bits = ^in_fetcher_pc[1:0];

    // The latched miss address doubles as the fill index/tag source.
    assign fill_idx = mem_pc_q[INDEX_BITS+1:2];
    assign fill_tag = mem_pc_q[ADDR_BITS-1:INDEX_BITS+2];
    assign fill_en  = rdy && !in_rob_misbranch && (state_q == MISS) && in_mem_ce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            fetcher_ce_q    <= 1'b0;
            fetcher_instr_q <= '0;
            mem_ce_q        <= 1'b0;
            mem_pc_q        <= '0;
        end else if (rdy) begin
            if (in_rob_misbranch) begin
                state_q      <= IDLE;
                fetcher_ce_q <= 1'b0;
                mem_ce_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        fetcher_ce_q <= 1'b0;
                        if (in_fetcher_ce) begin
                            if (req_hit) begin
                                fetcher_ce_q    <= 1'b1;
                                fetcher_instr_q <= data_q[req_idx];
                                state_q         <= DONE;
                            end else begin
                                mem_ce_q <= 1'b1;
                                mem_pc_q <= {in_fetcher_pc[31:2], 2'b00};
                                state_q  <= MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (in_mem_ce) begin
                            fetcher_ce_q    <= 1'b1;
                            fetcher_instr_q <= in_mem_instr;
                            mem_ce_q        <= 1'b0;
                            state_q         <= DONE;
                        end
                    end
                    DONE: begin
                        fetcher_ce_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                    default: begin
                        fetcher_ce_q <= 1'b0;
                        mem_ce_q     <= 1'b0;
                        state_q      <= IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= in_mem_instr;
        end
    end

    assign out_fetcher_ce    = fetcher_ce_q;
    assign out_fetcher_instr = fetcher_instr_q;
    assign out_mem_ce        = mem_ce_q;
    assign out_mem_pc        = mem_pc_q;

endmodule

// File: tb/tb_icache_direct.sv
// Testbench for icache_direct: vector table, hand-written corner sequences, and a randomized
// run against a line-level reference model of the cache.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_fetcher_ce;
    logic [31:0] in_fetcher_pc;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_instr;
    logic        out_mem_ce;
    logic [31:0] out_mem_pc;
    logic        in_mem_ce;
    logic [31:0] in_mem_instr;
    logic        in_rob_misbranch;

    int n_checks = 0;
    int n_pass   = 0;

    icache_direct #(.INDEX_BITS(6), .ADDR_BITS(18)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .in_fetcher_ce     (in_fetcher_ce),
        .in_fetcher_pc     (in_fetcher_pc),
        .out_fetcher_ce    (out_fetcher_ce),
        .out_fetcher_instr (out_fetcher_instr),
        .out_mem_ce        (out_mem_ce),
        .out_mem_pc        (out_mem_pc),
        .in_mem_ce         (in_mem_ce),
        .in_mem_instr      (in_mem_instr),
        .in_rob_misbranch  (in_rob_misbranch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mdata;
        int          delay;
        logic        exp_miss;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[10];

    // Reference model: one entry per line, indexed and tagged with plain arithmetic.
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_data  [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    // One complete fetch transaction; the fetcher keeps ce high through the DONE cycle.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] mdata, input int delay,
                         output logic miss, output logic [31:0] instr, output logic [31:0] mpc);
        logic held;
        in_fetcher_ce = 1'b1;
        in_fetcher_pc = pc;
        miss  = 1'b0;
        instr = '0;
        mpc   = '0;
        step();
        if (out_fetcher_ce) begin
            instr = out_fetcher_instr;
            check("hit_no_memreq", out_mem_ce, 0);
        end else if (out_mem_ce) begin
            miss = 1'b1;
            mpc  = out_mem_pc;
            held = 1'b1;
            for (int i = 0; i < delay; i++) begin
                step();
                if (!out_mem_ce || out_fetcher_ce || out_mem_pc !== mpc) held = 1'b0;
            end
            check("miss_req_held", held, 1);
            in_mem_ce    = 1'b1;
            in_mem_instr = mdata;
            step();
            in_mem_ce = 1'b0;
            check("fill_resp_ce", out_fetcher_ce, 1);
            check("fill_memce_drop", out_mem_ce, 0);
            instr = out_fetcher_instr;
        end else begin
            check("first_cycle_activity", out_fetcher_ce | out_mem_ce, 1);
        end
        step();
        check("done_ignored", {out_fetcher_ce, out_mem_ce}, 0);
        check("instr_hold", out_fetcher_instr, instr);
        in_fetcher_ce = 1'b0;
    endtask

    initial begin
        logic        miss;
        logic [31:0] instr;
        logic [31:0] mpc;
        logic        frozen;

        vecs[0] = '{32'h0000_0000, 32'h0000_0513, 5, 1'b1, 32'h0000_0513};
        vecs[1] = '{32'h0000_0000, 32'hDEAD_0001, 0, 1'b0, 32'h0000_0513};
        vecs[2] = '{32'h0000_0100, 32'h2222_2222, 2, 1'b1, 32'h2222_2222};
        vecs[3] = '{32'h0000_0000, 32'h1111_1111, 1, 1'b1, 32'h1111_1111};
        vecs[4] = '{32'h0000_0000, 32'hDEAD_0002, 0, 1'b0, 32'h1111_1111};
        vecs[5] = '{32'h0000_0104, 32'hAAAA_0001, 0, 1'b1, 32'hAAAA_0001};
        vecs[6] = '{32'h0000_0106, 32'hDEAD_0003, 0, 1'b0, 32'hAAAA_0001};
        vecs[7] = '{32'h0004_0000, 32'hDEAD_0004, 0, 1'b0, 32'h1111_1111};
        vecs[8] = '{32'h0003_FFFC, 32'h5A5A_5A5A, 3, 1'b1, 32'h5A5A_5A5A};
        vecs[9] = '{32'h0003_FFFF, 32'hDEAD_0005, 0, 1'b0, 32'h5A5A_5A5A};

        rst = 1'b1;
        rdy = 1'b1;
        in_fetcher_ce    = 1'b0;
        in_fetcher_pc    = '0;
        in_mem_ce        = 1'b0;
        in_mem_instr     = '0;
        in_rob_misbranch = 1'b0;
        step();
        step();
        check("rst_fetcher_ce", out_fetcher_ce, 0);
        check("rst_fetcher_instr", out_fetcher_instr, 0);
        check("rst_mem_ce", out_mem_ce, 0);
        check("rst_mem_pc", out_mem_pc, 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 10; v++) begin
            fetch(vecs[v].pc, vecs[v].mdata, vecs[v].delay, miss, instr, mpc);
            check($sformatf("vec%0d_miss", v), miss, vecs[v].exp_miss);
            check($sformatf("vec%0d_instr", v), instr, vecs[v].exp_instr);
            if (vecs[v].exp_miss) check($sformatf("vec%0d_mempc", v), mpc, vecs[v].pc & 32'hFFFF_FFFC);
        end

        // Misbranch coincident with an IDLE hit on line 0.
        in_fetcher_ce    = 1'b1;
        in_fetcher_pc    = 32'h0000_0000;
        in_rob_misbranch = 1'b1;
        step();
        in_rob_misbranch = 1'b0;
        in_fetcher_ce    = 1'b0;
        check("mb_hit_no_resp", out_fetcher_ce, 0);
        check("mb_hit_no_memreq", out_mem_ce, 0);
        step();

        // Misbranch two cycles into a miss, with a coincident late fill pulse.
        in_fetcher_ce = 1'b1;
        in_fetcher_pc = 32'h0000_0040;
        step();
        check("mb_miss_req", out_mem_ce, 1);
        step();
        in_rob_misbranch = 1'b1;
        in_mem_ce        = 1'b1;
        in_mem_instr     = 32'hBAD0_BAD0;
        in_fetcher_ce    = 1'b0;
        step();
        in_rob_misbranch = 1'b0;
        in_mem_ce        = 1'b0;
        check("mb_memce_drop", out_mem_ce, 0);
        check("mb_no_resp", out_fetcher_ce, 0);
        step();
        check("mb_no_late_resp", out_fetcher_ce, 0);
        fetch(32'h0000_0040, 32'h4040_4040, 1, miss, instr, mpc);
        check("mb_line_invalid", miss, 1);
        check("mb_refill_instr", instr, 32'h4040_4040);

        // rdy stall during MISS, with a fill pulse that must be ignored.
        in_fetcher_ce = 1'b1;
        in_fetcher_pc = 32'h0000_0080;
        step();
        check("stall_miss_req", out_mem_ce, 1);
        check("stall_miss_pc", out_mem_pc, 32'h0000_0080);
        rdy    = 1'b0;
        frozen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_mem_ce    = (i == 1);
            in_mem_instr = 32'hBADB_ADBA;
            step();
            if (!out_mem_ce || out_fetcher_ce || out_mem_pc !== 32'h0000_0080) frozen = 1'b0;
        end
        in_mem_ce = 1'b0;
        check("stall_frozen", frozen, 1);
        rdy = 1'b1;
        step();
        check("stall_still_miss", {out_fetcher_ce, out_mem_ce}, 2'b01);
        in_mem_ce    = 1'b1;
        in_mem_instr = 32'h8080_8080;
        step();
        in_mem_ce = 1'b0;
        check("stall_fill_ce", out_fetcher_ce, 1);
        check("stall_fill_instr", out_fetcher_instr, 32'h8080_8080);
        step();
        in_fetcher_ce = 1'b0;
        check("stall_done", out_fetcher_ce, 0);
        fetch(32'h0000_0080, 32'hDEAD_0006, 0, miss, instr, mpc);
        check("stall_hit", miss, 0);
        check("stall_hit_instr", instr, 32'h8080_8080);

        // Asynchronous reset between edges while in MISS.
        in_fetcher_ce = 1'b1;
        in_fetcher_pc = 32'h0000_0200;
        step();
        check("areset_miss_req", out_mem_ce, 1);
        #2 rst = 1'b1;
        #1;
        check("areset_memce", out_mem_ce, 0);
        check("areset_mempc", out_mem_pc, 0);
        check("areset_instr", out_fetcher_instr, 0);
        in_fetcher_ce = 1'b0;
        #1 rst = 1'b0;
        step();
        in_mem_ce    = 1'b1;
        in_mem_instr = 32'hBAD1_BAD1;
        step();
        in_mem_ce = 1'b0;
        check("areset_idle_fill_ignored", {out_fetcher_ce, out_mem_ce}, 0);
        fetch(32'h0000_0000, 32'h0C0C_0C0C, 0, miss, instr, mpc);
        check("areset_line0_invalid", miss, 1);
        fetch(32'h0000_0104, 32'h0D0D_0D0D, 0, miss, instr, mpc);
        check("areset_line1_invalid", miss, 1);

        // Randomized run against the reference model from a clean reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            logic [31:0] exp_instr;
            int          idx;
            logic [31:0] tag;
            bit          exp_hit;
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) pc = pc | ($urandom << 18);
            idx     = int'((pc / 4) % 64);
            tag     = (pc / 256) % 1024;
            exp_hit = m_valid[idx] && (m_tag[idx] == tag);
            if (exp_hit) begin
                exp_instr = m_data[idx];
            end else begin
                exp_instr    = memword(pc & 32'hFFFF_FFFC);
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = exp_instr;
            end
            fetch(pc, memword(pc & 32'hFFFF_FFFC), $urandom_range(0, 3), miss, instr, mpc);
            check("rand_miss", miss, !exp_hit);
            check("rand_instr", instr, exp_instr);
            if (!exp_hit) check("rand_mempc", mpc, pc & 32'hFFFF_FFFC);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
